// File: rtl/uart_pkg.sv
// Shared types and frame-config field positions for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int CFG_W      = 5;
  localparam int CFG_STOP   = 4;
  localparam int CFG_PEN    = 3;
  localparam int CFG_PEVEN  = 2;
  localparam int CFG_LEN_HI = 1;
  localparam int CFG_LEN_LO = 0;

  function automatic logic [CFG_W-1:0] cfg_make(input logic stop_sel, input logic parity_en,
                                                input logic parity_even, input logic [1:0] data_len);
    logic [CFG_W-1:0] c;
    c = '0;
    c[CFG_STOP]              = stop_sel;
    c[CFG_PEN]               = parity_en;
    c[CFG_PEVEN]             = parity_even;
    c[CFG_LEN_HI:CFG_LEN_LO] = data_len;
    return c;
  endfunction

endpackage

// File: rtl/uart_baud_div.sv
// Programmable divider producing the one-cycle clk16 oversampling enable.
module uart_baud_div (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        baud_en,
  input  logic [15:0] baud_div,
  output logic        clk16
);

  logic [15:0] cnt;

  // >= so that lowering baud_div below the running count wraps at once
  // instead of running the counter all the way round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      clk16 <= 1'b0;
    end else if (baud_en) begin
      if (cnt >= baud_div) begin
        cnt   <= '0;
        clk16 <= 1'b1;
      end else begin
        cnt   <= cnt + 16'd1;
        clk16 <= 1'b0;
      end
    end else begin
      clk16 <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one uart_core transmitter among N requesters.
//   state     | meaning
//   IDLE      | arbitrate pending requests
//   ISSUE     | pulse tx_req, arm start timeout
//   WAIT_BUSY | wait for tx_busy to rise, or time out
//   WAIT_DONE | wait for tx_busy to fall
//   GAP       | forced idle for GAP_TICKS clk16 pulses
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int N         = 4,
  parameter int GAP_TICKS = 16,
  parameter int START_TO  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           req,
  input  logic [8*N-1:0]         req_data,
  input  logic [CFG_W*N-1:0]     req_cfg,
  output logic [N-1:0]           ack,
  output logic [N-1:0]           done,
  output logic                   err,
  input  logic                   baud_en,
  input  logic [15:0]            baud_div,
  output logic                   clk16,
  output logic [7:0]             tx_data,
  output logic [CFG_W-1:0]       tx_cfg,
  output logic                   tx_req,
  input  logic                   tx_busy,
  output logic [$clog2(N)-1:0]   owner,
  output logic                   active
);

  localparam int IW = $clog2(N);

  state_t           state;
  logic [IW-1:0]    ptr;
  logic [15:0]      to_cnt;
  logic [15:0]      gap_cnt;
  logic [IW:0]      pick;
  logic [IW-1:0]    pick_idx;
  logic [7:0]       sel_data;
  logic [CFG_W-1:0] sel_cfg;

  // Scan from far to near so the last hit is the one closest after p.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] r, input logic [IW-1:0] p);
    logic [IW:0]   res;
    logic [IW-1:0] ix;
    int            idx;
    res = '0;
    for (int k = N; k >= 1; k--) begin
      idx = (int'(p) + k) % N;
      ix  = IW'(idx);
      if (r[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  uart_baud_div u_baud_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .baud_en  (baud_en),
    .baud_div (baud_div),
    .clk16    (clk16)
  );

  assign pick     = rr_pick(req, ptr);
  assign pick_idx = pick[IW-1:0];

  always_comb begin
    sel_data = '0;
    sel_cfg  = '0;
    for (int i = 0; i < N; i++) begin
      if (IW'(i) == pick_idx) begin
        sel_data = req_data[8*i +: 8];
        sel_cfg  = req_cfg[CFG_W*i +: CFG_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= IW'(N-1);
      ack     <= '0;
      done    <= '0;
      err     <= 1'b0;
      tx_req  <= 1'b0;
      tx_data <= '0;
      tx_cfg  <= '0;
      owner   <= '0;
      active  <= 1'b0;
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      ack    <= '0;
      done   <= '0;
      err    <= 1'b0;
      tx_req <= 1'b0;
      case (state)
        IDLE: begin
          if (pick[IW]) begin
            ack     <= onehot(pick_idx);
            tx_data <= sel_data;
            tx_cfg  <= sel_cfg;
            owner   <= pick_idx;
            ptr     <= pick_idx;
            active  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          tx_req <= 1'b1;
          to_cnt <= 16'(START_TO);
          state  <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (to_cnt == '0) begin
            done   <= onehot(owner);
            err    <= 1'b1;
            active <= 1'b0;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt - 16'd1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            done <= onehot(owner);
            if (GAP_TICKS == 0) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= 16'(GAP_TICKS);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (clk16) begin
            if (gap_cnt <= 16'd1) begin
              active <= 1'b0;
              state  <= IDLE;
            end else begin
              gap_cnt <= gap_cnt - 16'd1;
            end
          end
        end
        default: begin
          active <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: grant, gap, timeout, fairness, divider, reset.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req = '0;
  logic [8*N-1:0]       req_data = '0;
  logic [CFG_W*N-1:0]   req_cfg = '0;
  logic [N-1:0]         ack;
  logic [N-1:0]         done;
  logic                 err;
  logic                 baud_en = 1'b0;
  logic [15:0]          baud_div = 16'd3;
  logic                 clk16;
  logic [7:0]           tx_data;
  logic [CFG_W-1:0]     tx_cfg;
  logic                 tx_req;
  logic                 tx_busy = 1'b0;
  logic [$clog2(N)-1:0] owner;
  logic                 active;

  int n_cmp = 0;
  int n_err = 0;
  int done_seen = 0;

  uart_tx_scheduler #(.N(N), .GAP_TICKS(16), .START_TO(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .req_cfg  (req_cfg),
    .ack      (ack),
    .done     (done),
    .err      (err),
    .baud_en  (baud_en),
    .baud_div (baud_div),
    .clk16    (clk16),
    .tx_data  (tx_data),
    .tx_cfg   (tx_cfg),
    .tx_req   (tx_req),
    .tx_busy  (tx_busy),
    .owner    (owner),
    .active   (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done != '0) done_seen <= done_seen + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (ack == '0 && cyc < limit);
    if (ack == '0) begin
      n_cmp++;
      n_err++;
      $error("FAIL ack_wait: no ack within %0d cycles", limit);
    end
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (done == '0 && cyc < limit);
    if (done == '0) begin
      n_cmp++;
      n_err++;
      $error("FAIL done_wait: no done within %0d cycles", limit);
    end
  endtask

  task automatic wait_clk16(input int limit);
    int c;
    c = 0;
    do begin
      tick();
      c++;
    end while (!clk16 && c < limit);
    if (!clk16) begin
      n_cmp++;
      n_err++;
      $error("FAIL clk16_wait: no clk16 within %0d cycles", limit);
    end
  endtask

  initial begin
    int k;
    int d0;
    int cnt;
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 2};

    baud_en  = 1'b1;
    baud_div = 16'd3;
    req_data = {8'h44, 8'h33, 8'h22, 8'h55};
    req_cfg  = {cfg_make(1'b1, 1'b1, 1'b0, 2'b00), cfg_make(1'b0, 1'b1, 1'b1, 2'b00),
                cfg_make(1'b1, 1'b0, 1'b1, 2'b01), cfg_make(1'b0, 1'b0, 1'b0, 2'b11)};

    // reset state
    repeat (3) tick();
    chk("rst_ack",     32'(ack), 32'h0);
    chk("rst_done",    32'(done), 32'h0);
    chk("rst_err",     32'(err), 32'h0);
    chk("rst_tx_req",  32'(tx_req), 32'h0);
    chk("rst_clk16",   32'(clk16), 32'h0);
    chk("rst_active",  32'(active), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_tx_cfg",  32'(tx_cfg), 32'h0);
    chk("rst_owner",   32'(owner), 32'h0);
    rst_n = 1'b1;
    tick();

    // single request, real frame
    req = 4'b0001;
    tick();
    chk("t1_ack",     32'(ack), 32'h1);
    chk("t1_tx_data", 32'(tx_data), 32'h55);
    chk("t1_tx_cfg",  32'(tx_cfg), 32'h03);
    chk("t1_owner",   32'(owner), 32'h0);
    chk("t1_active",  32'(active), 32'h1);
    chk("t1_no_req_at_ack", 32'(tx_req), 32'h0);
    req = '0;
    tick();
    chk("t1_tx_req", 32'(tx_req), 32'h1);
    chk("t1_ack_one_cycle", 32'(ack), 32'h0);
    tx_busy = 1'b1;
    d0 = done_seen;
    repeat (40) tick();
    chk("t1_no_done_while_busy", 32'(done_seen - d0), 32'h0);
    tx_busy = 1'b0;
    tick();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_err",  32'(err), 32'h0);
    chk("t1_active_in_gap", 32'(active), 32'h1);

    // gap: 16 clk16 ticks at period 4 before the pending request is acked
    req = 4'b0010;
    wait_ack(80, k);
    chk("t3_gap_min", 32'(k >= 62), 32'h1);
    chk("t3_gap_max", 32'(k <= 65), 32'h1);
    chk("t3_ack",     32'(ack), 32'h2);
    chk("t3_tx_data", 32'(tx_data), 32'h22);
    req = '0;

    // start timeout: tx_busy never rises
    tick();
    chk("t4_tx_req", 32'(tx_req), 32'h1);
    wait_done(20, k);
    chk("t4_to_latency", 32'(k), 32'd9);
    chk("t4_done", 32'(done), 32'h2);
    chk("t4_err",  32'(err), 32'h1);
    req = 4'b0100;
    tick();
    chk("t4_next_ack", 32'(ack), 32'h4);
    chk("t4_no_coincide", 32'(done), 32'h0);
    req = '0;
    wait_done(20, k);

    // fairness from a fresh reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    req = 4'b1111;
    for (int g = 0; g < 6; g++) begin
      if (g == 4) req = 4'b0101;
      wait_ack(20, k);
      chk("t2_grant", 32'(ack), 32'(1) << exp_order[g]);
      chk("t2_owner", 32'(owner), 32'(exp_order[g]));
      req = req & ~ack;
      wait_done(20, k);
    end

    // divider
    wait_clk16(10);
    baud_div = 16'd0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clk16) cnt++;
    end
    chk("t5_div0_count", 32'(cnt), 32'd10);
    baud_div = 16'd4;
    wait_clk16(10);
    k = 0;
    do begin
      tick();
      k++;
    end while (!clk16 && k < 10);
    chk("t5_div4_period", 32'(k), 32'd5);
    repeat (2) tick();
    baud_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (clk16) cnt++;
    end
    chk("t5_disabled_count", 32'(cnt), 32'd0);
    baud_en = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
    end while (!clk16 && k < 10);
    chk("t5_frozen_resume", 32'(k), 32'd3);
    baud_div = 16'd3;

    // reset in WAIT_DONE
    req = 4'b0010;
    tick();
    chk("t6_ack", 32'(ack), 32'h2);
    req = '0;
    tick();
    tx_busy = 1'b1;
    repeat (3) tick();
    d0 = done_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_active",  32'(active), 32'h0);
    chk("t6_async_owner",   32'(owner), 32'h0);
    chk("t6_async_tx_data", 32'(tx_data), 32'h0);
    chk("t6_async_tx_cfg",  32'(tx_cfg), 32'h0);
    chk("t6_async_clk16",   32'(clk16), 32'h0);
    tx_busy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    req = 4'b1111;
    tick();
    chk("t6_first_grant", 32'(ack), 32'h1);
    chk("t6_no_done", 32'(done_seen - d0), 32'h0);
    req = '0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
